prog_mem_loader: RTL and testbench

Parametrised, loadable program memory for the processor fetch path. Replaces the fixed, combinationally read, initial-block ROM with a synchronous RAM that is filled at boot through a streaming load port and then serves instruction fetches with one-cycle latency and bounds checking. It sits between the boot/host interface and the processor's program counter/fetch stage.

---
 rtl/prog_mem_pkg.sv | 12 +
 rtl/prog_mem_ram.sv | 33 +++
 rtl/prog_mem_loader.sv | 114 +++++++++++
 tb/tb_prog_mem_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and default sizing for the loadable program memory.
package prog_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module prog_mem_ram
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // No reset on the array or read register so this maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Loadable program memory: streaming boot load, then bounds-checked
// instruction fetch with one-cycle latency.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  input  logic              reload,
  output logic              prog_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              wr_en;
  logic              fetch_ok;
  logic              resp_valid_reg, resp_ok_reg;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    case (state_reg)
      LOAD: begin
        // A reload while loading restarts the program and drops this cycle's word.
        if (reload) begin
          wptr_next  = '0;
          count_next = '0;
        end else if (ld_valid) begin
          wr_en      = 1'b1;
          wptr_next  = wptr_reg + 1'b1;
          count_next = count_reg + 1'b1;
          if (ld_last || (wptr_reg == ADDR_W'(DEPTH - 1))) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Request is good only against the current program; reload takes priority.
  assign fetch_ok = fetch_req && (state_reg == RUN) && !reload &&
                    ({1'b0, fetch_addr} < count_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_ok_reg    <= 1'b0;
    end else begin
      resp_valid_reg <= fetch_req;
      resp_ok_reg    <= fetch_ok;
    end
  end

  prog_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en && !rst),
    .wr_addr (wptr_reg),
    .wr_data (ld_data),
    .rd_en   (fetch_req),
    .rd_addr (fetch_addr),
    .rd_data (rd_data)
  );

  assign ld_ready    = (state_reg == LOAD);
  assign prog_ready  = (state_reg == RUN);
  assign ld_count    = count_reg;
  assign fetch_valid = resp_valid_reg;
  assign fetch_err   = resp_valid_reg && !resp_ok_reg;
  // The RAM read register is unreset; the ok flag masks it to zero on errors.
  assign fetch_data  = resp_ok_reg ? rd_data : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized self-checking bench for prog_mem_loader against a simple array model.
module tb_prog_mem_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              reload = 1'b0;
  logic              prog_ready;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  always #5 clk = ~clk;

  prog_mem_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count),
    .reload(reload), .prog_ready(prog_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err)
  );

  int errors = 0;
  int checks = 0;

  // Model: program image, its length, and whether it is runnable.
  logic [DATA_W-1:0] mem_m [DEPTH];
  int                count_m = 0;
  bit                run_m = 1'b0;
  logic              exp_v, exp_e;
  logic [DATA_W-1:0] exp_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
  endtask

  // Predict the response to the current request, advance the model, clock once.
  task automatic step();
    bit ok;
    ok    = fetch_req && run_m && !reload && (int'(fetch_addr) < count_m);
    exp_v = fetch_req;
    exp_e = fetch_req && !ok;
    exp_d = ok ? mem_m[fetch_addr] : '0;
    if (reload) begin
      count_m = 0;
      run_m   = 1'b0;
    end else if (!run_m && ld_valid) begin
      mem_m[count_m] = ld_data;
      count_m++;
      if (ld_last || count_m == DEPTH) run_m = 1'b1;
    end
    tick();
  endtask

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return 32'h8040_0001 + 32'(i) * 32'h0040_0001;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%b want=1", ld_ready); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL reset_prog_ready got=%b want=0", prog_ready); end
    checks++; if (ld_count !== 6'd0) begin errors++; $display("FAIL reset_ld_count got=%0d want=0", ld_count); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b want=0", fetch_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got=%b want=0", fetch_err); end
    checks++; if (fetch_data !== '0) begin errors++; $display("FAIL reset_fetch_data got=%h want=0", fetch_data); end
    rst = 1'b0;
    count_m = 0; run_m = 1'b0;
    $display("reset: ld_ready=%b prog_ready=%b ld_count=%0d", ld_ready, prog_ready, ld_count);
  endtask

  task automatic test_load_fetch();
    for (int i = 0; i < 18; i++) begin
      ld_valid = 1'b1; ld_data = pattern(i); ld_last = (i == 17);
      step();
      checks++; if (ld_count !== 6'(i + 1)) begin errors++; $display("FAIL load18_count i=%0d got=%0d want=%0d", i, ld_count, i + 1); end
      checks++; if (prog_ready !== (i == 17)) begin errors++; $display("FAIL load18_prog_ready i=%0d got=%b want=%b", i, prog_ready, i == 17); end
    end
    idle_inputs();
    for (int a = 0; a < 18; a++) begin
      fetch_req = 1'b1; fetch_addr = ADDR_W'(a);
      step();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== pattern(a)) begin
        errors++; $display("FAIL fetch18 addr=%0d got v=%b e=%b d=%h want v=1 e=0 d=%h", a, fetch_valid, fetch_err, fetch_data, pattern(a));
      end
      $display("fetch addr=%0d data=%h err=%b", a, fetch_data, fetch_err);
      step();
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL idle_no_valid addr=%0d got=%b want=0", a, fetch_valid); end
    end
  endtask

  task automatic test_out_of_range();
    int addrs [2] = '{18, 31};
    foreach (addrs[k]) begin
      fetch_req = 1'b1; fetch_addr = ADDR_W'(addrs[k]);
      step();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_data !== '0) begin
        errors++; $display("FAIL out_of_range addr=%0d got v=%b e=%b d=%h want v=1 e=1 d=0", addrs[k], fetch_valid, fetch_err, fetch_data);
      end
      $display("oor fetch addr=%0d err=%b data=%h", addrs[k], fetch_err, fetch_data);
    end
  endtask

  task automatic test_reload_collision();
    fetch_req = 1'b1; fetch_addr = '0; reload = 1'b1;
    step();
    idle_inputs();
    checks++; if (fetch_err !== 1'b1 || fetch_valid !== 1'b1 || fetch_data !== '0) begin errors++; $display("FAIL reload_fetch got v=%b e=%b d=%h want v=1 e=1 d=0", fetch_valid, fetch_err, fetch_data); end
    checks++; if (ld_ready !== 1'b1 || prog_ready !== 1'b0) begin errors++; $display("FAIL reload_state got ld_ready=%b prog_ready=%b want 1/0", ld_ready, prog_ready); end
    checks++; if (ld_count !== 6'd0) begin errors++; $display("FAIL reload_count got=%0d want=0", ld_count); end
    fetch_req = 1'b1; fetch_addr = '0;
    step();
    idle_inputs();
    checks++; if (fetch_err !== 1'b1 || fetch_data !== '0) begin errors++; $display("FAIL fetch_in_load got e=%b d=%h want e=1 d=0", fetch_err, fetch_data); end
    // Reload while loading discards partial program and the word offered with it.
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = $urandom;
      step();
    end
    reload = 1'b1;
    step();
    idle_inputs();
    checks++; if (ld_count !== 6'd0 || ld_ready !== 1'b1) begin errors++; $display("FAIL reload_in_load got count=%0d ld_ready=%b want 0/1", ld_count, ld_ready); end
    $display("reload: ld_count=%0d ld_ready=%b", ld_count, ld_ready);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
      step();
      checks++; if (prog_ready !== (i == DEPTH - 1)) begin errors++; $display("FAIL full_prog_ready i=%0d got=%b want=%b", i, prog_ready, i == DEPTH - 1); end
    end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'($urandom);
      step();
      checks++; if (ld_ready !== 1'b0 || ld_count !== 6'd32) begin errors++; $display("FAIL full_ignore got ld_ready=%b count=%0d want 0/32", ld_ready, ld_count); end
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      fetch_req = 1'b1; fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      step();
      checks++; if (fetch_valid !== exp_v || fetch_err !== exp_e || fetch_data !== exp_d) begin errors++; $display("FAIL full_fetch got v=%b e=%b d=%h want v=%b e=%b d=%h", fetch_valid, fetch_err, fetch_data, exp_v, exp_e, exp_d); end
    end
    idle_inputs();
    $display("full load: ld_count=%0d", ld_count);
  endtask

  task automatic test_reset_midload();
    reload = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = $urandom;
      step();
    end
    fetch_req = 1'b1; fetch_addr = '0; ld_valid = 1'b1; ld_data = $urandom;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (ld_count !== 6'd0 || ld_ready !== 1'b1 || prog_ready !== 1'b0) begin errors++; $display("FAIL midrst_state got count=%0d ld_ready=%b prog_ready=%b", ld_count, ld_ready, prog_ready); end
    tick();
    checks++; if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_data !== '0) begin errors++; $display("FAIL midrst_fetch got v=%b e=%b d=%h want 0/0/0", fetch_valid, fetch_err, fetch_data); end
    checks++; if (ld_count !== 6'd0) begin errors++; $display("FAIL midrst_count_held got=%0d want=0", ld_count); end
    rst = 1'b0;
    idle_inputs();
    count_m = 0; run_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = (i == 2);
      step();
    end
    idle_inputs();
    checks++; if (ld_count !== 6'd3 || prog_ready !== 1'b1) begin errors++; $display("FAIL reload3 got count=%0d prog_ready=%b want 3/1", ld_count, prog_ready); end
    for (int a = 0; a < 3; a++) begin
      fetch_req = 1'b1; fetch_addr = ADDR_W'(a);
      step();
      checks++; if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== exp_d) begin errors++; $display("FAIL reload3_fetch addr=%0d got e=%b d=%h want e=0 d=%h", a, fetch_err, fetch_data, exp_d); end
      $display("after reset fetch addr=%0d data=%h", a, fetch_data);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    reload = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 18; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = (i == 17);
      step();
    end
    idle_inputs();
    for (int a = 0; a < 18; a++) begin
      fetch_req = 1'b1; fetch_addr = ADDR_W'(a);
      step();
      if (fetch_valid === 1'b1) got++;
      checks++; if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== exp_d) begin errors++; $display("FAIL b2b addr=%0d got v=%b e=%b d=%h want v=1 e=0 d=%h", a, fetch_valid, fetch_err, fetch_data, exp_d); end
    end
    idle_inputs();
    checks++; if (got != 18) begin errors++; $display("FAIL b2b_count got=%0d want=18", got); end
    $display("back-to-back responses=%0d", got);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, DEPTH);
      int guard = 0;
      reload = 1'b1;
      step();
      idle_inputs();
      while (!run_m && guard < 300) begin
        guard++;
        ld_valid = ($urandom_range(0, 3) != 0);
        ld_data  = $urandom;
        ld_last  = (count_m == len - 1);
        fetch_req = 1'($urandom); fetch_addr = ADDR_W'($urandom);
        step();
        checks++; if (ld_count !== 6'(count_m) || prog_ready !== run_m || ld_ready !== !run_m) begin errors++; $display("FAIL rand_load r=%0d got count=%0d pr=%b want count=%0d pr=%b", r, ld_count, prog_ready, count_m, run_m); end
        checks++; if (fetch_valid !== exp_v || fetch_err !== exp_e || fetch_data !== exp_d) begin errors++; $display("FAIL rand_load_fetch r=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h", r, fetch_valid, fetch_err, fetch_data, exp_v, exp_e, exp_d); end
      end
      idle_inputs();
      for (int c = 0; c < 24; c++) begin
        fetch_req  = ($urandom_range(0, 3) != 0);
        fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        reload     = ($urandom_range(0, 29) == 0);
        ld_valid   = 1'($urandom); ld_data = $urandom;
        step();
        checks++; if (fetch_valid !== exp_v || fetch_err !== exp_e || fetch_data !== exp_d) begin errors++; $display("FAIL rand_fetch r=%0d addr=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h", r, fetch_addr, fetch_valid, fetch_err, fetch_data, exp_v, exp_e, exp_d); end
        checks++; if (ld_count !== 6'(count_m) || prog_ready !== run_m) begin errors++; $display("FAIL rand_state r=%0d got count=%0d pr=%b want count=%0d pr=%b", r, ld_count, prog_ready, count_m, run_m); end
      end
      idle_inputs();
      $display("random round=%0d len=%0d count=%0d", r, len, ld_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_out_of_range();
    test_reload_collision();
    test_full_load();
    test_reset_midload();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
